// File: rtl/inst_loader.sv
// Byte-stream program loader for the instruction-cache debug write port.
// Optional read-back checksum verify is enabled by defining LOADER_VERIFY_EN.
module inst_loader #(
  parameter int          DEPTH     = 4096,
  parameter logic [29:0] BASE_WORD = 30'd0,
  parameter int          CNT_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             dbg_we,
  output logic [29:0]      dbg_addr,
  output logic [31:0]      dbg_wdata,
  input  logic [31:0]      dbg_rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_WRITE, S_VERIFY, S_VCHK, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [31:0] word_reg;
  logic [31:0] asm_word;
  logic        last_seen;
  logic        wc_full;

`ifdef LOADER_VERIFY_EN
  logic [31:0]      wr_sum;
  logic [31:0]      rd_sum;
  logic [CNT_W-1:0] vidx;
`else
  logic unused_rdata;
  assign unused_rdata = ^dbg_rdata;
`endif

  assign s_ready = (state == S_RECV);
  assign wc_full = (word_count == CNT_W'(DEPTH));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    asm_word = word_reg;
    asm_word[{lane, 3'b000} +: 8] = s_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lane       <= 2'd0;
      word_reg   <= 32'd0;
      last_seen  <= 1'b0;
      word_count <= '0;
      dbg_we     <= 1'b0;
      dbg_addr   <= BASE_WORD;
      dbg_wdata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_VERIFY_EN
      wr_sum     <= 32'd0;
      rd_sum     <= 32'd0;
      vidx       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state      <= S_RECV;
            lane       <= 2'd0;
            word_reg   <= 32'd0;
            last_seen  <= 1'b0;
            word_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            wr_sum     <= 32'd0;
            rd_sum     <= 32'd0;
`endif
          end
        end

        S_RECV: begin
          if (s_valid) begin
            if (wc_full) begin
              // Cache is full: refuse the byte and never issue the write.
              state <= S_ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (lane == 2'd3 || s_last) begin
              state     <= S_WRITE;
              dbg_we    <= 1'b1;
              dbg_addr  <= BASE_WORD + 30'(word_count);
              dbg_wdata <= asm_word;
              last_seen <= s_last;
            end else begin
              word_reg <= asm_word;
              lane     <= lane + 2'd1;
            end
          end
        end

        S_WRITE: begin
          dbg_we     <= 1'b0;
          word_count <= word_count + CNT_W'(1);
          lane       <= 2'd0;
          word_reg   <= 32'd0;
`ifdef LOADER_VERIFY_EN
          wr_sum     <= wr_sum ^ dbg_wdata;
`endif
          if (last_seen) begin
`ifdef LOADER_VERIFY_EN
            state    <= S_VERIFY;
            dbg_addr <= BASE_WORD;
            vidx     <= CNT_W'(1);
`else
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            state <= S_RECV;
          end
        end

`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          // Read data lags the address by one cycle; the first cycle has none.
          if (vidx != CNT_W'(1))
            rd_sum <= rd_sum ^ dbg_rdata;
          if (vidx == word_count) begin
            state <= S_VCHK;
          end else begin
            dbg_addr <= BASE_WORD + 30'(vidx);
            vidx     <= vidx + CNT_W'(1);
          end
        end

        S_VCHK: begin
          busy <= 1'b0;
          if ((rd_sum ^ dbg_rdata) == wr_sum) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected debug writes are queued as bytes
// are driven and popped by a monitor when dbg_we is seen.
module tb_inst_loader;

  localparam int          DEPTH     = 4;
  localparam logic [29:0] BASE_WORD = 30'd0;
  localparam int          CNT_W     = 13;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             dbg_we;
  logic [29:0]      dbg_addr;
  logic [31:0]      dbg_wdata;
  logic [31:0]      dbg_rdata;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  wr_seen = 0;
  int  last_we_cyc = 0;
  bit  corrupt = 1'b0;
  wr_t exp_q [$];

  inst_loader #(.DEPTH(DEPTH), .BASE_WORD(BASE_WORD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read cache model; optionally corrupts word 1 on readback.
  logic [31:0] mem [0:7];
  always @(posedge clk) begin
    if (dbg_we) mem[dbg_addr[2:0]] <= dbg_wdata;
    dbg_rdata <= mem[dbg_addr[2:0]] ^ ((corrupt && dbg_addr == 30'd1) ? 32'h0000_0100 : 32'h0);
  end

  always @(negedge clk) begin
    if (!rst && dbg_we) begin
      wr_t e;
      wr_seen++;
      last_we_cyc = cyc;
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_in_write: s_ready=%b want 0", s_ready);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h data=%h", dbg_addr, dbg_wdata);
      end else begin
        e = exp_q.pop_front();
        if (dbg_addr !== e.addr || dbg_wdata !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                   dbg_addr, dbg_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    logic acc = 1'b0;
    int   n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = b; s_last = last;
    while (!acc && n < 50) begin
      acc = s_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL byte_timeout: byte=%h not accepted in 50 cycles", b);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h5A;
  endtask

  // Queue expected writes, stream the bytes, then check the session outcome.
  task automatic load(input bq_t b, input bit gaps, input bit exp_err, input string name);
    logic [31:0] w = 32'd0;
    int widx = 0;
    int wr0 = wr_seen;
    int n = 0;
    int exp_lat;
    int exp_words;
    for (int i = 0; i < b.size(); i++) begin
      w[(i % 4) * 8 +: 8] = b[i];
      if ((i % 4) == 3 || i == b.size() - 1) begin
        if (widx < DEPTH) exp_q.push_back('{addr: BASE_WORD + 30'(widx), data: w});
        widx++;
        w = 32'd0;
      end
    end
    exp_words = (widx < DEPTH) ? widx : DEPTH;
`ifdef LOADER_VERIFY_EN
    exp_lat = exp_words + 2;
`else
    exp_lat = 1;
`endif
    pulse_start();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== '0) begin
      bad++;
      $display("FAIL %s_start: busy=%b done=%b error=%b wc=%0d want 1 0 0 0",
               name, busy, done, error, word_count);
    end
    for (int i = 0; i < b.size(); i++) begin
      drive_byte(b[i], i == b.size() - 1);
      if (gaps) begin
        @(negedge clk); s_valid = 1'b0;
      end
    end
    idle_bus();
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== !exp_err || error !== exp_err || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: done=%b error=%b busy=%b want done=%b error=%b busy=0",
               name, done, error, busy, !exp_err, exp_err);
    end
    total++;
    if (word_count !== CNT_W'(exp_words) || (wr_seen - wr0) != exp_words) begin
      bad++;
      $display("FAIL %s_count: wc=%0d writes=%0d want %0d", name, word_count, wr_seen - wr0, exp_words);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: %0d writes not seen want 0", name, exp_q.size());
      exp_q.delete();
    end
    if (!exp_err) begin
      total++;
      if (cyc - last_we_cyc != exp_lat) begin
        bad++;
        $display("FAIL %s_latency: %0d cycles write->done want %0d", name, cyc - last_we_cyc, exp_lat);
      end
    end
    // Status must stay sticky while idle.
    repeat (3) @(negedge clk);
    total++;
    if (done !== !exp_err || error !== exp_err) begin
      bad++;
      $display("FAIL %s_sticky: done=%b error=%b", name, done, error);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || dbg_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || dbg_addr !== BASE_WORD || dbg_wdata !== 32'd0 || word_count !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d",
               s_ready, dbg_we, busy, done, error, dbg_addr, dbg_wdata, word_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_state: s_ready=%b busy=%b want 0 0", s_ready, busy);
    end
  endtask

  task automatic test_basic();
    bq_t q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00};
    load(q, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_partial();
    bq_t q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load(q, 1'b0, 1'b0, "partial");
  endtask

  task automatic test_gaps();
    bq_t q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h11, 8'h00, 8'h00, 8'h91, 8'h82};
    load(q, 1'b1, 1'b0, "gaps");
  endtask

  task automatic test_overflow();
    bq_t q;
    for (int i = 0; i < 17; i++) q.push_back(8'(8'h40 + i));
    load(q, 1'b0, 1'b1, "overflow");
    q = {8'h01, 8'h02, 8'h03, 8'h04};
    load(q, 1'b0, 1'b0, "after_overflow");
  endtask

  task automatic test_reset_mid_write();
    bq_t q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    exp_q.push_back('{addr: BASE_WORD, data: 32'h4030_2010});
    pulse_start();
    for (int i = 0; i < 8; i++) drive_byte(q[i], 1'b0);
    #1;
    total++;
    if (dbg_we !== 1'b1 || dbg_addr !== BASE_WORD + 30'd1) begin
      bad++;
      $display("FAIL rst_pre: we=%b addr=%h want 1 %h", dbg_we, dbg_addr, BASE_WORD + 30'd1);
    end
    rst = 1'b1;
    #1;
    total++;
    if (dbg_we !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        dbg_addr !== BASE_WORD || dbg_wdata !== 32'd0 || word_count !== '0) begin
      bad++;
      $display("FAIL rst_mid_write: we=%b rdy=%b busy=%b done=%b err=%b addr=%h wdata=%h wc=%0d",
               dbg_we, s_ready, busy, done, error, dbg_addr, dbg_wdata, word_count);
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk); rst = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_first_write: %0d writes not seen want 0", exp_q.size());
      exp_q.delete();
    end
    q = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
    load(q, 1'b0, 1'b0, "after_reset");
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify_corrupt();
    bq_t q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    corrupt = 1'b1;
    load(q, 1'b0, 1'b1, "verify_corrupt");
    corrupt = 1'b0;
    load(q, 1'b0, 1'b0, "verify_good");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_gaps();
    test_overflow();
    test_reset_mid_write();
`ifdef LOADER_VERIFY_EN
    test_verify_corrupt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction-cache debug port: receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses through the cache's debug write interface (debug_addr, debug_input, write_en).
- Sits between the host/debug transport and the instruction cache; used to load test programs before releasing the CPU from reset.

Parameters:
- DEPTH, 4096, cache capacity in words; load beyond this is an error.
- BASE_WORD, 0, first word address written (30-bit word address).
- CNT_W, 13, width of word counter (must hold DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: begin a load session
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_last  in  1  marks final byte of program (qualified by s_valid)
- s_ready  out  1  loader accepts byte this cycle
- dbg_we  out  1  debug write enable to cache
- dbg_addr  out  30  debug word address (bits [31:2])
- dbg_wdata  out  32  debug write data
- dbg_rdata  in  32  debug read data, valid one cycle after dbg_addr (registered cache read)
- busy  out  1  session in progress
- done  out  1  load completed successfully; sticky until next start
- error  out  1  overflow or verify mismatch; sticky until next start
- word_count  out  CNT_W  words written this session

Behaviour:
- Reset (async): state IDLE; s_ready, dbg_we, busy, done, error = 0; dbg_addr = BASE_WORD; dbg_wdata = 0; word_count = 0; byte lane counter = 0. Reset mid-write aborts immediately (dbg_we deasserts with reset); no partial session state survives.
- All outputs are registered except s_ready, which is a decode of the state.
- IDLE: s_ready = 0. On start: clear word_count, done, error and lane; go to RECV. busy = 1 in every state except IDLE/DONE/ERROR.
- start outside IDLE/DONE/ERROR is ignored.
- RECV: s_ready = 1. A byte is accepted on s_valid & s_ready and placed in lane 0..3 (lane 0 -> bits [7:0]).
  - Go to WRITE when lane 3 is filled or s_last is accepted.
  - If s_last arrives on lane <3, unfilled upper bytes are zero.
- WRITE (1 cycle): s_ready = 0; dbg_we = 1, dbg_addr = BASE_WORD + word_count, dbg_wdata = assembled word. Next cycle: word_count increments, lane and word register clear.
  - Then: if last seen -> VERIFY (feature on) or DONE; else RECV.
- Throughput: minimum 5 cycles per word (4 accept + 1 write).
- Overflow: a byte accepted while word_count == DEPTH -> ERROR; no write is issued.
- s_last with zero bytes is impossible; s_last always carries a data byte.
- DONE: done = 1, busy = 0; hold until start. ERROR: error = 1, busy = 0; hold until start.
- word_count holds its final value in DONE/ERROR.

Optional Feature:
- Macro LOADER_VERIFY_EN.
- Defined:
  - During WRITE, XOR each written word into wr_sum.
  - After the final write, VERIFY presents dbg_addr = BASE_WORD + i for i = 0..word_count-1, one per cycle, with dbg_we = 0.
  - dbg_rdata is XORed into rd_sum one cycle later; a VCHK state absorbs the last read.
  - wr_sum == rd_sum -> DONE; otherwise -> ERROR.
  - Verify adds word_count + 1 cycles.
- Undefined: no checksum registers; WRITE of the last word goes directly to DONE; dbg_rdata is unused.

Test Plan:
- Reset then start; stream bytes 13 00 00 00, 37 11 00 00 (last on 8th byte) -> WRITE cycles with addr 0 data 0x00000013, addr 1 data 0x00001137; word_count = 2; done = 1.
- Partial word: 5 bytes AA BB CC DD EE (last on EE) -> second write addr 1 data 0x000000EE; done = 1.
- Backpressure/gaps: toggle s_valid every other cycle -> identical writes. s_ready = 0 during each WRITE cycle; no byte is lost or duplicated.
- Overflow with DEPTH = 4: stream 17 bytes -> 4 writes, then error = 1 on the 17th byte, with no 5th write. A new start clears error.
- Async rst asserted during a WRITE cycle -> dbg_we drops the same cycle; all outputs reach reset values. A later start loads normally from BASE_WORD.
- With LOADER_VERIFY_EN, a cache model corrupting word 1 on readback -> error = 1, done = 0. With a faithful model -> done = 1 after word_count + 1 verify cycles.
